// File: rtl/frame_fifo_sc.sv
// Single-clock frame FIFO: stores sof/eof-delimited frames, commits only complete good
// frames, keeps lengths in a side FIFO and replays frames as a valid/ready stream.
module frame_fifo_sc #(
    parameter int P_DATA_W     = 8,
    parameter int P_DEPTH      = 4096,
    parameter int P_LEN_W      = 11,
    parameter int P_MAX_FRAMES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [P_DATA_W-1:0]           wr_data,
    input  logic                          wr_vld,
    output logic                          wr_rdy,
    input  logic                          wr_sof,
    input  logic                          wr_eof,
    input  logic                          wr_abort,
    output logic [P_DATA_W-1:0]           rd_data,
    output logic                          rd_vld,
    input  logic                          rd_rdy,
    output logic                          rd_sof,
    output logic                          rd_eof,
    output logic [P_LEN_W-1:0]            rd_len,
    output logic [$clog2(P_MAX_FRAMES):0] frm_cnt,
    output logic [15:0]                   drop_cnt,
    output logic                          full,
    output logic                          empty
);
    localparam int C_PTR_BITS = $clog2(P_DEPTH);
    localparam int C_LF_BITS  = $clog2(P_MAX_FRAMES);

    typedef logic [C_PTR_BITS:0] ptr_t;
    typedef logic [C_LF_BITS:0]  lptr_t;
    typedef logic [P_LEN_W-1:0]  len_t;

    localparam ptr_t  C_DEPTH    = ptr_t'(P_DEPTH);
    localparam ptr_t  C_PTR_ONE  = ptr_t'(1);
    localparam lptr_t C_LF_DEPTH = lptr_t'(P_MAX_FRAMES);
    localparam lptr_t C_LF_ONE   = lptr_t'(1);
    localparam len_t  C_LEN_ONE  = len_t'(1);
    localparam len_t  C_LEN_MAX  = '1;

    typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DISCARD} w_state_e;
    typedef enum logic       {R_IDLE, R_READ}             r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    ptr_t  wr_commit_q, wr_commit_d;
    ptr_t  wr_spec_q, wr_spec_d;
    ptr_t  rd_ptr_q;
    len_t  wr_len_q, wr_len_d;
    lptr_t lf_wp_q, lf_rp_q;
    len_t  remaining_q, rd_len_q;
    logic  first_q;
    logic  [P_DATA_W-1:0] rd_data_q;
    logic  rd_vld_q, rd_sof_q, rd_eof_q;
    logic  [15:0] drop_cnt_q;

    logic  [P_DATA_W-1:0] mem [P_DEPTH];
    len_t                 lf_mem [P_MAX_FRAMES];

    logic                  mem_we;
    logic [C_PTR_BITS-1:0] mem_waddr;
    logic                  lf_push, lf_pop, lf_full, lf_empty;
    len_t                  lf_push_len;
    logic                  drop, start, fetch, rd_stop;
    ptr_t                  used_spec, used_commit;
    lptr_t                 lf_used;

    assign used_spec   = wr_spec_q - rd_ptr_q;
    assign used_commit = wr_commit_q - rd_ptr_q;
    assign lf_used     = lf_wp_q - lf_rp_q;
    assign lf_full     = (lf_used == C_LF_DEPTH);
    assign lf_empty    = (lf_used == '0);

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_d   = w_state_q;
        wr_spec_d   = wr_spec_q;
        wr_commit_d = wr_commit_q;
        wr_len_d    = wr_len_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_spec_q[C_PTR_BITS-1:0];
        lf_push     = 1'b0;
        lf_push_len = wr_len_q;
        drop        = 1'b0;
        start       = 1'b0;
        case (w_state_q)
            W_IDLE: start = wr_vld && wr_sof;
            W_FRAME: begin
                if (wr_abort) begin
                    drop      = 1'b1;
                    wr_spec_d = wr_commit_q;
                    w_state_d = W_IDLE;
                end else if (wr_vld && wr_sof) begin
                    drop  = 1'b1;
                    start = 1'b1;
                end else if (wr_vld) begin
                    if (full || wr_len_q == C_LEN_MAX) begin
                        drop      = 1'b1;
                        wr_spec_d = wr_commit_q;
                        w_state_d = W_DISCARD;
                    end else if (wr_eof && lf_full) begin
                        drop      = 1'b1;
                        wr_spec_d = wr_commit_q;
                        w_state_d = W_IDLE;
                    end else begin
                        mem_we    = 1'b1;
                        wr_spec_d = wr_spec_q + C_PTR_ONE;
                        wr_len_d  = wr_len_q + C_LEN_ONE;
                        if (wr_eof) begin
                            lf_push     = 1'b1;
                            lf_push_len = wr_len_q + C_LEN_ONE;
                            wr_commit_d = wr_spec_q + C_PTR_ONE;
                            w_state_d   = W_IDLE;
                        end
                    end
                end
            end
            W_DISCARD: begin
                if (wr_abort)               w_state_d = W_IDLE;
                else if (wr_vld && wr_sof)  start     = 1'b1;
                else if (wr_vld && wr_eof)  w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase

        // A new frame always starts at the commit pointer, whatever state it interrupts.
        if (start) begin
            wr_spec_d = wr_commit_q;
            if (used_commit == C_DEPTH) begin
                drop      = 1'b1;
                w_state_d = W_DISCARD;
            end else if (wr_eof && lf_full) begin
                drop      = 1'b1;
                w_state_d = W_IDLE;
            end else begin
                mem_we    = 1'b1;
                mem_waddr = wr_commit_q[C_PTR_BITS-1:0];
                wr_spec_d = wr_commit_q + C_PTR_ONE;
                wr_len_d  = C_LEN_ONE;
                if (wr_eof) begin
                    lf_push     = 1'b1;
                    lf_push_len = C_LEN_ONE;
                    wr_commit_d = wr_commit_q + C_PTR_ONE;
                    w_state_d   = W_IDLE;
                end else begin
                    w_state_d = W_FRAME;
                end
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        lf_pop    = 1'b0;
        fetch     = 1'b0;
        rd_stop   = 1'b0;
        case (r_state_q)
            R_IDLE: if (!lf_empty) begin
                lf_pop    = 1'b1;
                r_state_d = R_READ;
            end
            R_READ: if (!rd_vld_q || rd_rdy) begin
                if (remaining_q != '0) begin
                    fetch = 1'b1;
                end else begin
                    rd_stop   = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
        endcase
    end

    // NOTE: storage arrays carry no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (mem_we)  mem[mem_waddr] <= wr_data;
        if (lf_push) lf_mem[lf_wp_q[C_LF_BITS-1:0]] <= lf_push_len;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            wr_commit_q <= '0;
            wr_spec_q   <= '0;
            wr_len_q    <= '0;
            rd_ptr_q    <= '0;
            lf_wp_q     <= '0;
            lf_rp_q     <= '0;
            remaining_q <= '0;
            rd_len_q    <= '0;
            first_q     <= 1'b0;
            rd_data_q   <= '0;
            rd_vld_q    <= 1'b0;
            rd_sof_q    <= 1'b0;
            rd_eof_q    <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            wr_commit_q <= wr_commit_d;
            wr_spec_q   <= wr_spec_d;
            wr_len_q    <= wr_len_d;
            if (lf_push) lf_wp_q <= lf_wp_q + C_LF_ONE;
            if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            if (lf_pop) begin
                lf_rp_q     <= lf_rp_q + C_LF_ONE;
                rd_len_q    <= lf_mem[lf_rp_q[C_LF_BITS-1:0]];
                remaining_q <= lf_mem[lf_rp_q[C_LF_BITS-1:0]];
                first_q     <= 1'b1;
            end
            if (fetch) begin
                rd_data_q   <= mem[rd_ptr_q[C_PTR_BITS-1:0]];
                rd_vld_q    <= 1'b1;
                rd_sof_q    <= first_q;
                rd_eof_q    <= (remaining_q == C_LEN_ONE);
                rd_ptr_q    <= rd_ptr_q + C_PTR_ONE;
                remaining_q <= remaining_q - C_LEN_ONE;
                first_q     <= 1'b0;
            end else if (rd_stop) begin
                rd_vld_q <= 1'b0;
            end
        end
    end

    assign wr_rdy   = 1'b1;
    assign rd_data  = rd_data_q;
    assign rd_vld   = rd_vld_q;
    assign rd_sof   = rd_sof_q;
    assign rd_eof   = rd_eof_q;
    assign rd_len   = rd_len_q;
    assign frm_cnt  = lf_used;
    assign drop_cnt = drop_cnt_q;
    assign full     = (used_spec == C_DEPTH);
    assign empty    = lf_empty && !rd_vld_q;

endmodule

// File: tb/tb_frame_fifo_sc.sv
// Bench for frame_fifo_sc: small instance (16-beat RAM, 4-bit lengths) so overflow,
// oversize and length-FIFO limits are reachable; output beats checked against a scoreboard.
module tb_frame_fifo_sc;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_vld, wr_rdy, wr_sof, wr_eof, wr_abort;
    logic [7:0] rd_data;
    logic       rd_vld, rd_rdy, rd_sof, rd_eof;
    logic [3:0] rd_len;
    logic [4:0] frm_cnt;
    logic [15:0] drop_cnt;
    logic       full, empty;

    frame_fifo_sc #(
        .P_DATA_W(8), .P_DEPTH(16), .P_LEN_W(4), .P_MAX_FRAMES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_data(wr_data), .wr_vld(wr_vld), .wr_rdy(wr_rdy),
        .wr_sof(wr_sof), .wr_eof(wr_eof), .wr_abort(wr_abort),
        .rd_data(rd_data), .rd_vld(rd_vld), .rd_rdy(rd_rdy),
        .rd_sof(rd_sof), .rd_eof(rd_eof), .rd_len(rd_len),
        .frm_cnt(frm_cnt), .drop_cnt(drop_cnt), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
        logic [3:0] len;
    } beat_t;

    typedef struct {
        int         n;
        logic [7:0] base;
        int         cut;
        bit         abort;
        bit         commit;
        int         drops;
    } vec_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic sof, input logic eof);
        wr_vld  = 1'b1;
        wr_data = d;
        wr_sof  = sof;
        wr_eof  = eof;
        tick();
        wr_vld  = 1'b0;
        wr_sof  = 1'b0;
        wr_eof  = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [7:0] base, input bit push);
        beat_t e;
        for (int i = 0; i < n; i++) begin
            if (push) begin
                e.d   = 8'(base + 8'(i));
                e.sof = (i == 0);
                e.eof = (i == n - 1);
                e.len = 4'(n);
                sb.push_back(e);
            end
            beat(8'(base + 8'(i)), i == 0, i == n - 1);
        end
    endtask

    task automatic drain(input bit rnd, input int budget);
        int n = 0;
        while (!(sb.size() == 0 && empty) && n < budget) begin
            rd_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        rd_rdy = 1'b1;
        check("drain_done", n < budget, 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rd_vld"}, rd_vld, 0);
        check({tag, "_rd_sof"}, rd_sof, 0);
        check({tag, "_rd_eof"}, rd_eof, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_len"}, rd_len, 0);
        check({tag, "_frm_cnt"}, frm_cnt, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_wr_rdy"}, wr_rdy, 1);
    endtask

    // Output monitor: pops the scoreboard on each handshake and checks hold-while-stalled.
    initial begin
        beat_t e, h;
        bit    held;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1 || rd_vld !== 1'b1) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("stall_data", rd_data, h.d);
                    check("stall_sof", rd_sof, h.sof);
                    check("stall_eof", rd_eof, h.eof);
                end
                if (rd_rdy) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got 0x%0h expected no beat", rd_data);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", rd_data, e.d);
                        check("out_sof", rd_sof, e.sof);
                        check("out_eof", rd_eof, e.eof);
                        check("out_len", rd_len, e.len);
                    end
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    h    = '{d: rd_data, sof: rd_sof, eof: rd_eof, len: rd_len};
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[6];
        logic [15:0] d0;

        // Frame scenarios: cut = beats of a preceding partial frame (data 0xE0..),
        // ended by abort or by the next sof; commit = whether the main frame comes out.
        vecs[0] = '{4,  8'h30, 0, 1'b0, 1'b1, 0};
        vecs[1] = '{6,  8'h40, 4, 1'b1, 1'b1, 1};
        vecs[2] = '{3,  8'h50, 2, 1'b0, 1'b1, 1};
        vecs[3] = '{16, 8'h60, 0, 1'b0, 1'b0, 1};
        vecs[4] = '{15, 8'h70, 0, 1'b0, 1'b1, 0};
        vecs[5] = '{1,  8'h80, 0, 1'b0, 1'b1, 0};

        rst_n = 1'b0; wr_data = '0; wr_vld = 1'b0; wr_sof = 1'b0; wr_eof = 1'b0;
        wr_abort = 1'b0; rd_rdy = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check_idle("rst1");

        // 5-beat frame: eof accepted in cycle N, first beat visible in N+3
        rd_rdy = 1'b1;
        send_frame(5, 8'h10, 1);
        @(negedge clk); check("lat_n1_vld", rd_vld, 0);
        @(negedge clk); check("lat_n2_vld", rd_vld, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("lat_vld", rd_vld, 1);
            check("lat_data", rd_data, 8'h10 + 8'(k));
            check("lat_sof", rd_sof, k == 0);
            check("lat_eof", rd_eof, k == 4);
            check("lat_len", rd_len, 5);
        end
        drain(0, 50);
        check("t1_drops", drop_cnt, 0);

        // 1-beat frame then two more with output stalled; the first is already started
        rd_rdy = 1'b0;
        send_frame(1, 8'hAA, 1);
        send_frame(3, 8'h20, 1);
        send_frame(2, 8'h28, 1);
        check("t2_frm_cnt", frm_cnt, 2);
        check("t2_empty", empty, 0);
        drain(0, 100);

        // Overflow: 10-beat frame stalled (its first beat fetched), 8-beat frame overflows
        rd_rdy = 1'b0;
        d0 = drop_cnt;
        send_frame(10, 8'hA0, 1);
        for (int i = 0; i < 7; i++) beat(8'hB0 + 8'(i), i == 0, 1'b0);
        check("t3_full_before", full, 1);
        beat(8'hB7, 1'b0, 1'b1);
        check("t3_full_after", full, 0);
        check("t3_drops", 16'(drop_cnt - d0), 1);
        check("t3_frm_cnt", frm_cnt, 0);
        drain(0, 100);

        // Table-driven frame scenarios
        for (int v = 0; v < 6; v++) begin
            d0 = drop_cnt;
            rd_rdy = 1'b1;
            for (int i = 0; i < vecs[v].cut; i++) beat(8'hE0 + 8'(i), i == 0, 1'b0);
            if (vecs[v].cut > 0 && vecs[v].abort) begin
                wr_abort = 1'b1;
                tick();
                wr_abort = 1'b0;
            end
            send_frame(vecs[v].n, vecs[v].base, vecs[v].commit);
            drain(0, 200);
            check($sformatf("vec%0d_drops", v), 16'(drop_cnt - d0), vecs[v].drops);
            check($sformatf("vec%0d_full", v), full, 0);
            check($sformatf("vec%0d_frm_cnt", v), frm_cnt, 0);
        end

        // Stall mid-frame for 5 cycles, then random ready
        rd_rdy = 1'b0;
        send_frame(12, 8'h90, 1);
        repeat (3) tick();
        rd_rdy = 1'b1;
        repeat (3) tick();
        rd_rdy = 1'b0;
        repeat (5) tick();
        drain(1, 400);

        // Length FIFO limit: first frame is popped, so 17 fit and the 18th is dropped
        rd_rdy = 1'b0;
        d0 = drop_cnt;
        for (int f = 0; f < 18; f++) send_frame(1, 8'hC0 + 8'(f), f < 17);
        check("t6_drops", 16'(drop_cnt - d0), 1);
        check("t6_frm_cnt", frm_cnt, 16);
        check("t6_full", full, 1);
        rst_n = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
        check_idle("rst2");
        send_frame(3, 8'hD0, 1);
        drain(0, 100);
        check("t6_post_drops", drop_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
